lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Parametrised, multi-cycle load/store controller for the execute stage. Decodes RISC-V load/store `opcode_E` and `fun3_E`, and builds aligned byte-lane masks and lane-shifted store data. Issues each access over a valid/grant request channel with a separate read-response channel, stalling the pipeline until the access completes. Load results are sign- or zero-extended to XLEN, and misaligned or illegal accesses are flagged without touching memory.

## Interface
Parameters:
- `XLEN`, 32: data/address width; legal values 32 or 64.
- `NB`, XLEN/8: byte lanes (derived, not overridden).

Ports. Clock and reset are one clock with an asynchronous, active-high reset.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  execute stage holds a valid instruction
- `opcode_E`  in  7  0000011 = load, 0100011 = store; anything else is ignored
- `fun3_E`  in  3  access size and sign
- `addr`  in  XLEN  effective byte address
- `wdata`  in  XLEN  store source (rs2)
- `stall`  out  1  freeze the pipeline
- `load_valid`  out  1  one-cycle pulse; `load_data` is valid
- `load_data`  out  XLEN  extended load result
- `fault`  out  1  one-cycle pulse; access rejected
- `fault_cause`  out  2  01 = misaligned load, 10 = misaligned store, 11 = illegal fun3
- `mem_req`  out  1  request valid
- `mem_we`  out  1  1 = write
- `mem_addr`  out  XLEN  address aligned to NB (low log2(NB) bits are 0)
- `mem_mask`  out  NB  byte enables
- `mem_wdata`  out  XLEN  lane-positioned store data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  XLEN  read data

## Operation
Legal fun3 values:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. With XLEN=64, also 011 LD and 110 LWU.
- Stores: 000 SB, 001 SH, 010 SW. With XLEN=64, also 011 SD.
- Any other fun3 is illegal.

Address and alignment:
- `off = addr[log2(NB)-1:0]`.
- Halfword requires `off[0]=0`. Word requires `off[1:0]=0`. Doubleword requires `off=0`.

Masks and store data:
- Mask is `1<<off`, `3<<off`, `4'hF<<off`, or all-ones, by size.
- `mem_wdata = (wdata & size_mask) << 8*off`. Unmasked lanes are don't-care but driven 0.

Load data:
- Extracted as `mem_rdata >> 8*off`, truncated to size, then sign-extended (LB/LH/LW/LD) or zero-extended (LBU/LHU/LWU).

State machine (IDLE, REQ, WAIT, DONE):
- **IDLE**, on `req_valid` and load/store opcode:
  - Illegal or misaligned: `fault=1` with its cause (combinational, this cycle only), `stall=0`, stay in IDLE, no memory access.
  - Otherwise: register address, mask, write data and fun3; `stall=1`; go to REQ.
- **REQ**: `mem_req=1` with stable attributes until `mem_gnt`.
  - Store with grant: go to DONE.
  - Load with grant: go to WAIT.
- **WAIT**: on `mem_rvalid`, register the extended data and go to DONE. `mem_rvalid` during the grant cycle is not legal for the memory and is ignored.
- **DONE**: `stall=0`, and `load_valid=1` for loads only. Go to IDLE. No new request is accepted in DONE, so the retiring instruction is never re-issued.

Other rules:
- `mem_rvalid` outside WAIT is ignored.
- `stall` is 1 in the accepting IDLE cycle, in REQ and in WAIT.
- An asynchronous reset in any state returns to IDLE, drops `mem_req` immediately, and discards any pending response.

## Timing
- Reset values: state IDLE; `stall`, `load_valid`, `fault`, `mem_req`, `mem_we` all 0; `fault_cause`, `load_data`, `mem_addr`, `mem_mask`, `mem_wdata` all 0.
- Minimum store latency: accept at T0, `mem_req` at T1 with grant at T1, DONE at T2. `stall` is high for T0–T1 (2 cycles).
- Minimum load latency: accept T0, grant T1, rvalid T2, DONE/`load_valid` at T3. `stall` is high for 3 cycles.
- Each cycle of grant or rvalid delay adds one stall cycle.
- `mem_*` outputs are registered. `stall` and `fault` are combinational from state and inputs.

## Test plan
- XLEN=32, SB at addr 0x1003, wdata 0x123456A5, immediate grant: `mem_addr` 0x1000, `mem_mask` 1000, `mem_wdata` 0xA5000000, `stall` high exactly 2 cycles, no `load_valid`.
- LH at 0x2002, `mem_rdata` 0x8001_7FFF: `load_data` 0xFFFF8001. LHU at the same address: 0x00008001. Mask 1100 for both.
- LW at 0x3000 with grant delayed 3 cycles and rvalid 2 cycles after grant: `mem_req` held stable 4 cycles, `stall` high 7 cycles, `load_valid` one pulse with `mem_rdata` passed through.
- LW at 0x1001: `fault=1` and cause 01 for one cycle, `stall=0`, `mem_req` never asserted. SH at 0x1001 gives cause 10. fun3 011 with XLEN=32 gives cause 11.
- XLEN=64, LWU at 0x...4, `mem_rdata` 0xF0000000_00000000: mask 0xF0, `load_data` 0x00000000_F0000000. SD at 0x...8: mask 0xFF.
- Assert `rst` while in WAIT, then drive `mem_rvalid` after release: outputs return to reset values immediately, no `load_valid` pulse, and the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Execute-stage load/store controller: decodes, aligns and issues one
// memory access at a time over a valid/grant + read-response channel.
module lsu_mem_ctrl #(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [6:0]      opcode_E,
  input  logic [2:0]      fun3_E,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [NB-1:0]   mem_mask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int OW = $clog2(NB);
  localparam bit IS64 = (XLEN == 64);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] ldata_q, ldata_d;
  logic [NB-1:0]   mask_q, mask_d;
  logic [2:0]      fun3_q, fun3_d;
  logic [OW-1:0]   off_q, off_d;
  logic            we_q, we_d;
  logic            req_q, req_d;

  logic            is_ld, is_st, legal, misal;
  logic            req_ok, accept, bad;
  logic [OW-1:0]   off;
  logic [1:0]      sz;
  logic [NB-1:0]   bmask;
  logic [XLEN-1:0] sdata, shr, lmask, ext;
  logic            sgn;

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] s);
    unique case (s)
      2'd0:    return XLEN'(64'hFF);
      2'd1:    return XLEN'(64'hFFFF);
      2'd2:    return XLEN'(64'hFFFF_FFFF);
      default: return '1;
    endcase
  endfunction

  // Decode and legality of the instruction presented in IDLE
  always_comb begin
    is_ld = (opcode_E == 7'b0000011);
    is_st = (opcode_E == 7'b0100011);
    off   = addr[OW-1:0];
    sz    = fun3_E[1:0];
    legal = 1'b0;
    if (is_ld)
      legal = (fun3_E != 3'b111) &&
              (IS64 || (fun3_E != 3'b011 && fun3_E != 3'b110));
    if (is_st)
      legal = !fun3_E[2] && (IS64 || sz != 2'b11);
    unique case (sz)
      2'd0:    misal = 1'b0;
      2'd1:    misal = off[0];
      2'd2:    misal = |off[1:0];
      default: misal = |off;
    endcase
    unique case (sz)
      2'd0:    bmask = NB'(1);
      2'd1:    bmask = NB'(3);
      2'd2:    bmask = NB'(15);
      default: bmask = '1;
    endcase
    sdata  = (wdata & size_mask(sz)) << {off, 3'b000};
    req_ok = req_valid && (is_ld || is_st) && (state_q == IDLE);
    bad    = req_ok && (!legal || misal);
    accept = req_ok && legal && !misal;
  end

  // Load extraction from the registered lane offset and size
  always_comb begin
    shr   = mem_rdata >> {off_q, 3'b000};
    lmask = size_mask(fun3_q[1:0]);
    unique case (fun3_q[1:0])
      2'd0:    sgn = shr[7];
      2'd1:    sgn = shr[15];
      2'd2:    sgn = shr[31];
      default: sgn = shr[XLEN-1];
    endcase
    ext = (shr & lmask) | ((!fun3_q[2] && sgn) ? ~lmask : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      mask_q  <= '0;
      fun3_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      mask_q  <= mask_d;
      fun3_q  <= fun3_d;
      off_q   <= off_d;
      we_q    <= we_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    mask_d  = mask_q;
    fun3_d  = fun3_q;
    off_d   = off_q;
    we_d    = we_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = is_st;
          addr_d  = {addr[XLEN-1:OW], OW'(0)};
          mask_d  = bmask << off;
          wdata_d = sdata;
          fun3_d  = fun3_E;
          off_d   = off;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          ldata_d = ext;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall       = accept || (state_q == REQ) || (state_q == WAIT);
    fault       = bad;
    fault_cause = 2'b00;
    if (bad)
      fault_cause = !legal ? 2'b11 : (is_st ? 2'b10 : 2'b01);
    load_valid  = (state_q == DONE) && !we_q;
  end

  assign load_data = ldata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_mask  = mask_q;
  assign mem_wdata = wdata_q;

endmodule
